// File: rtl/sdram_coalescer_pkg.sv
// Shared types and constants for the SDRAM write coalescer.
// Holds the controller state encoding and default burst/flush sizing.
package sdram_coalescer_pkg;

    localparam int MAX_BURST  = 16;
    localparam int IDLE_FLUSH = 8;
    localparam int ROW_BITS   = 10;
    localparam int ADDR_W     = 23;
    localparam int DATA_W     = 32;
    localparam int MASK_W     = 4;
    localparam int BUF_W      = DATA_W + MASK_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WR_CMD,
        ST_WR_DATA,
        ST_RD_CMD,
        ST_RD_WAIT
    } state_t;

    // Word-aligned form of a host byte address.
    function automatic logic [ADDR_W-1:0] align_word(input logic [ADDR_W-1:0] a);
        return a & ~ADDR_W'(3);
    endfunction

endpackage

// File: rtl/sdram_wbuf.sv
// Write burst buffer: one synchronous write port and one asynchronous read port.
// Each entry packs {mask, data}; contents carry no reset.
module sdram_wbuf
    import sdram_coalescer_pkg::*;
#(
    parameter int DEPTH = MAX_BURST,
    parameter int WIDTH = BUF_W,
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             sys_clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge sys_clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/sdram_wr_coalescer.sv
// Coalesces sequential host writes into SDRAM bursts and passes reads through,
// draining any buffered burst before a read is accepted.
module sdram_wr_coalescer #(
    parameter int MAX_BURST  = sdram_coalescer_pkg::MAX_BURST,
    parameter int IDLE_FLUSH = sdram_coalescer_pkg::IDLE_FLUSH
) (
    input  logic        sys_clk,
    input  logic        reset,
    input  logic        h_req,
    input  logic        h_we,
    input  logic [22:0] h_addr,
    input  logic [31:0] h_wdata,
    input  logic [3:0]  h_wmask,
    input  logic [3:0]  h_len,
    input  logic        h_flush,
    output logic        h_ready,
    output logic [31:0] h_rdata,
    output logic        h_rvalid,
    output logic        cmd,
    output logic        cmd_en,
    input  logic        cmd_ack,
    output logic [3:0]  cmd_len,
    output logic [22:0] addr,
    output logic [31:0] wr_data,
    output logic [3:0]  wr_mask,
    input  logic [31:0] rd_data,
    input  logic        rd_data_valid
);

    import sdram_coalescer_pkg::*;

    localparam int CNT_W  = $clog2(MAX_BURST + 1);
    localparam int IDX_W  = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam int IDLE_W = $clog2(IDLE_FLUSH + 1);

    state_t             state;
    state_t             next_state;
    logic [22:0]        base;
    logic [CNT_W-1:0]   count;
    logic [IDLE_W-1:0]  idle_cnt;
    logic [IDX_W-1:0]   beat;
    logic [22:0]        rd_addr;
    logic [3:0]         rd_len;
    logic [3:0]         rd_cnt;

    logic               appendable;
    logic [20:0]        next_word;
    logic               buf_we;
    logic [IDX_W-1:0]   buf_waddr;
    logic [IDX_W-1:0]   buf_raddr;
    logic [BUF_W-1:0]   buf_rdata;

    sdram_wbuf #(
        .DEPTH (MAX_BURST),
        .WIDTH (BUF_W)
    ) u_wbuf (
        .sys_clk (sys_clk),
        .we      (buf_we),
        .waddr   (buf_waddr),
        .wdata   ({h_wmask, h_wdata}),
        .raddr   (buf_raddr),
        .rdata   (buf_rdata)
    );

    // A write extends the burst only if it is the next word, fits, and stays in the row.
    always_comb begin
        next_word  = base[22:2] + 21'(count);
        appendable = h_req && h_we && !h_flush
                     && (h_addr[22:2] == next_word)
                     && (count < CNT_W'(MAX_BURST))
                     && (h_addr[22:ROW_BITS] == base[22:ROW_BITS]);
    end

    always_comb begin
        next_state = state;
        h_ready    = 1'b0;
        cmd_en     = 1'b0;
        cmd        = 1'b0;
        cmd_len    = 4'd0;
        addr       = 23'd0;
        wr_data    = 32'd0;
        wr_mask    = 4'd0;
        buf_we     = 1'b0;
        buf_waddr  = '0;
        buf_raddr  = '0;
        case (state)
            ST_IDLE: begin
                h_ready = 1'b1;
                if (h_req) begin
                    if (h_we) begin
                        buf_we     = 1'b1;
                        next_state = ST_COLLECT;
                    end else begin
                        next_state = ST_RD_CMD;
                    end
                end
            end
            ST_COLLECT: begin
                h_ready = appendable;
                if (appendable) begin
                    buf_we    = 1'b1;
                    buf_waddr = count[IDX_W-1:0];
                    if (count == CNT_W'(MAX_BURST - 1)) begin
                        next_state = ST_WR_CMD;
                    end
                end else if (h_flush || h_req) begin
                    next_state = ST_WR_CMD;
                end else if (idle_cnt == IDLE_W'(IDLE_FLUSH - 1)) begin
                    next_state = ST_WR_CMD;
                end
            end
            ST_WR_CMD: begin
                cmd_en             = 1'b1;
                cmd                = 1'b1;
                addr               = base;
                cmd_len            = 4'(count - CNT_W'(1));
                {wr_mask, wr_data} = buf_rdata;
                if (cmd_ack) begin
                    next_state = (count == CNT_W'(1)) ? ST_IDLE : ST_WR_DATA;
                end
            end
            ST_WR_DATA: begin
                buf_raddr          = beat;
                {wr_mask, wr_data} = buf_rdata;
                if (CNT_W'(beat) == count - CNT_W'(1)) begin
                    next_state = ST_IDLE;
                end
            end
            ST_RD_CMD: begin
                cmd_en  = 1'b1;
                addr    = rd_addr;
                cmd_len = rd_len;
                if (cmd_ack) begin
                    next_state = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (rd_data_valid && (rd_cnt == rd_len)) begin
                    next_state = ST_IDLE;
                end
            end
            default: next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            base     <= '0;
            count    <= '0;
            idle_cnt <= '0;
            beat     <= '0;
            rd_addr  <= '0;
            rd_len   <= '0;
            rd_cnt   <= '0;
        end else begin
            state <= next_state;
            case (state)
                ST_IDLE: begin
                    if (h_req && h_we) begin
                        base     <= align_word(h_addr);
                        count    <= CNT_W'(1);
                        idle_cnt <= '0;
                    end else if (h_req) begin
                        rd_addr <= align_word(h_addr);
                        rd_len  <= h_len;
                        rd_cnt  <= '0;
                    end
                end
                ST_COLLECT: begin
                    if (appendable) begin
                        count    <= count + 1'b1;
                        idle_cnt <= '0;
                    end else if (!h_req) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
                ST_WR_CMD:  beat <= IDX_W'(1);
                ST_WR_DATA: beat <= beat + 1'b1;
                ST_RD_WAIT: begin
                    if (rd_data_valid) begin
                        rd_cnt <= rd_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Read beats are forwarded one cycle late; stray beats outside RD_WAIT are dropped.
    always_ff @(posedge sys_clk or posedge reset) begin
        if (reset) begin
            h_rvalid <= 1'b0;
            h_rdata  <= 32'd0;
        end else begin
            h_rvalid <= (state == ST_RD_WAIT) && rd_data_valid;
            if ((state == ST_RD_WAIT) && rd_data_valid) begin
                h_rdata <= rd_data;
            end
        end
    end

endmodule

// File: doc/sdram_wr_coalescer.md
SDRAM_WR_COALESCER -- requirements
Module: sdram_wr_coalescer

Interface
REQ-001 SHALL have parameter MAX_BURST, default 16: maximum coalesced write burst length, in words.
REQ-002 SHALL have parameter IDLE_FLUSH, default 8: number of sys_clk cycles with no host request in COLLECT before the buffered burst is flushed.
REQ-003 sys_clk  input  1  clock; all logic on its rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 h_req  input  1  host request valid.
REQ-006 h_we  input  1  1 = write, 0 = read.
REQ-007 h_addr  input  23  byte address, word aligned (bits 1:0 ignored).
REQ-008 h_wdata  input  32  write word.
REQ-009 h_wmask  input  4  byte mask, 1 = byte not written (DQM polarity).
REQ-010 h_len  input  4  read length minus 1 (0..15); ignored on writes.
REQ-011 h_flush  input  1  force out any buffered write burst.
REQ-012 h_ready  output  1  request accepted in the cycle where h_req and h_ready are both high.
REQ-013 h_rdata  output  32  read data.
REQ-014 h_rvalid  output  1  h_rdata valid, one pulse per read beat.
REQ-015 cmd  output  1  command to sdramc: 0 = read, 1 = write.
REQ-016 cmd_en  output  1  command valid.
REQ-017 cmd_ack  input  1  sdramc accepted the command.
REQ-018 cmd_len  output  4  burst length minus 1.
REQ-019 addr  output  23  burst start byte address.
REQ-020 wr_data  output  32  write beat data.
REQ-021 wr_mask  output  4  write beat mask.
REQ-022 rd_data  input  32  sdramc read data.
REQ-023 rd_data_valid  input  1  sdramc read beat valid.

Function
REQ-024 SHALL implement states IDLE, COLLECT, WR_CMD, WR_DATA, RD_CMD and RD_WAIT.
REQ-025 IDLE: h_ready=1; an accepted write SHALL store the word and mask in buf[0], latch base=h_addr, set count=1 and go to COLLECT; an accepted read SHALL latch h_addr and h_len and go to RD_CMD.
REQ-026 COLLECT: h_ready SHALL be combinationally high only when the request is appendable, i.e. all of:
  - h_req, h_we and !h_flush;
  - h_addr == base + 4*count;
  - count < MAX_BURST;
  - h_addr[22:10] == base[22:10] (no 1 KiB row crossing).
REQ-027 An appendable write SHALL store the word in buf[count], increment count and clear the idle counter.
REQ-028 COLLECT SHALL go to WR_CMD on any of:
  - a non-appendable request (left pending, h_ready=0);
  - h_flush;
  - count reaching MAX_BURST;
  - the idle counter reaching IDLE_FLUSH.
REQ-029 WR_CMD: cmd_en=1, cmd=1, addr=base, cmd_len=count-1, wr_data/wr_mask=buf[0]; all held stable until cmd_ack is sampled high.
REQ-030 After cmd_ack, beat k (1..count-1) SHALL drive wr_data/wr_mask=buf[k] on the k-th cycle after the ack cycle (WR_DATA), then go to IDLE.
REQ-031 When count==1, the block SHALL go from WR_CMD directly to IDLE after the ack.
REQ-032 RD_CMD: cmd_en=1, cmd=0, addr=latched address, cmd_len=latched h_len, held until cmd_ack.
REQ-033 RD_WAIT: each rd_data_valid SHALL be forwarded to h_rvalid/h_rdata one cycle later (registered); after h_len+1 beats the block SHALL go to IDLE.
REQ-034 Ordering: a read arriving while writes are buffered SHALL not be accepted until the write burst has been issued, so read-after-write returns the new data.
REQ-035 cmd_en SHALL deassert in the cycle after the cmd_ack cycle; a cmd_ack outside WR_CMD/RD_CMD SHALL be ignored.
REQ-036 h_ready SHALL be 0 in WR_CMD, WR_DATA, RD_CMD and RD_WAIT.
REQ-037 Address arithmetic SHALL be 23-bit; the 1 KiB row rule makes wrap-around impossible within a burst.

Reset
REQ-038 On reset the state SHALL become IDLE, count=0, idle counter=0, and the buffer is discarded.
REQ-039 On reset cmd_en, cmd, cmd_len, addr, wr_data, wr_mask, h_rvalid and h_rdata SHALL be 0.
REQ-040 Reset mid-burst SHALL abandon the burst immediately; no further beats are driven.

Structure
REQ-041 Package sdram_coalescer_pkg SHALL hold the state enum, MAX_BURST, IDLE_FLUSH and the ROW_BITS=10 constant.
REQ-042 The buffer SHALL be a sub-module sdram_wbuf: MAX_BURST x 36 bits, one write port, one asynchronous-read port.

Verification
REQ-043 Cover: 4 writes to 0x000,0x004,0x008,0x00C, then idle -> one WR_CMD with addr=0, cmd_len=3 after 8 idle cycles; beats 0..3 in order.
REQ-044 Cover: 17 sequential writes from 0x020 -> burst 1 with cmd_len=15, then burst 2 at 0x060 with cmd_len=0.
REQ-045 Cover: writes to 0x3F8, 0x3FC, 0x400 -> two bursts (0x3F8 with len 1; 0x400 with len 0) due to the row rule.
REQ-046 Cover: write 0x100=0xA5A5A5A5 immediately followed by a read of 0x100 with len 0 -> write command precedes read; h_rdata=0xA5A5A5A5.
REQ-047 Cover: cmd_ack delayed 5 cycles -> cmd_en, addr, cmd_len and wr_data stable throughout the wait.
REQ-048 Cover: reset asserted during WR_DATA beat 2 of 4 -> all outputs 0 next cycle; IDLE with h_ready=1 after release.
